keypad_entry_ctrl: RTL and testbench

Sequencing controller between the keypad debouncer and the cook timer. Turns debounced key levels into single key events, accumulates up to four BCD digits as an MM:SS cook time and hands the time to the timer over a valid/ready load handshake. It then issues start and stop commands and returns to idle when cooking finishes. It owns the microwave's user-entry state.

---
 rtl/keypad_entry_ctrl_pkg.sv | 28 ++
 rtl/keypad_entry_ctrl_if.sv | 27 ++
 rtl/keypad_entry_ctrl_key_event_detect.sv | 35 +++
 rtl/keypad_entry_ctrl.sv | 170 +++++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_entry_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_pkg: shared state encoding, key codes and BCD helpers          |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [3:0] KEY_START = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam int         BCD_W     = 16;
  localparam logic [7:0] SEC_MAX   = 8'h59;

  function automatic logic [BCD_W-1:0] clamp_seconds(input logic [BCD_W-1:0] t);
    logic [BCD_W-1:0] r;
    r = t;
    if (t[7:0] > SEC_MAX) r[7:0] = SEC_MAX;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_entry_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_entry_ctrl_if: load handshake and start/stop link to the timer |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
interface keypad_entry_ctrl_if;
  import keypad_pkg::*;

  logic             load_valid;
  logic             load_ready;
  logic [BCD_W-1:0] load_time;
  logic             start;
  logic             stop;
  logic             timer_busy;

  modport master (
    output load_valid, load_time, start, stop,
    input  load_ready, timer_busy
  );

  modport slave (
    input  load_valid, load_time, start, stop,
    output load_ready, timer_busy
  );

endinterface
`default_nettype wire

// File: rtl/keypad_entry_ctrl_key_event_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_event_detect: one event per key press plus key-code decode        |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module key_event_detect
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_level,
  input  logic [3:0] key_code,
  output logic       key_ev,
  output logic       is_digit,
  output logic       is_start,
  output logic       is_clear
);

  logic r_key_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_key_prev <= 1'b0;
    else     r_key_prev <= key_level;
  end

  // Decoded flags are qualified by the event so a held key acts once.
  always_comb begin
    key_ev   = key_level & ~r_key_prev;
    is_digit = key_ev & (key_code <= 4'd9);
    is_start = key_ev & (key_code == KEY_START);
    is_clear = key_ev & (key_code == KEY_CLEAR);
  end

endmodule
`default_nettype wire

// File: rtl/keypad_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | keypad_entry_ctrl: key entry, MM:SS buffer, timer load/start/stop     |
// | Option: KEYPAD_SEC_CLAMP_EN clamps seconds to 59 on entry to LOAD      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int CNT_W          = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_level,
  input  logic [3:0]            key_code,
  input  logic                  door_closed,
  keypad_entry_ctrl_if.master   tmr,
  output logic [BCD_W-1:0]      disp_bcd,
  output logic                  error
);

  localparam bit               c_timeout_en = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] c_cnt_last   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic w_key_ev, w_is_digit, w_is_start, w_is_clear;

  key_event_detect u_key_event_detect (
    .clk       (clk),
    .rst       (rst),
    .key_level (key_level),
    .key_code  (key_code),
    .key_ev    (w_key_ev),
    .is_digit  (w_is_digit),
    .is_start  (w_is_start),
    .is_clear  (w_is_clear)
  );

  state_t           r_state, w_state_nxt;
  logic [BCD_W-1:0] r_buf, w_buf_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy_prev;
  logic             r_load_valid, w_load_valid_nxt;
  logic             r_start, w_start_nxt;
  logic             r_stop, w_stop_nxt;
  logic             r_error, w_error_nxt;
  logic             w_busy_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_buf        <= '0;
      r_cnt        <= '0;
      r_busy_prev  <= 1'b0;
      r_load_valid <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_buf        <= w_buf_nxt;
      r_cnt        <= w_cnt_nxt;
      r_busy_prev  <= tmr.timer_busy;
      r_load_valid <= w_load_valid_nxt;
      r_start      <= w_start_nxt;
      r_stop       <= w_stop_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // Branch order inside each state encodes CLEAR > door > key > timeout > finish.
  always_comb begin
    w_state_nxt      = r_state;
    w_buf_nxt        = r_buf;
    w_cnt_nxt        = r_cnt;
    w_load_valid_nxt = 1'b0;
    w_start_nxt      = 1'b0;
    w_stop_nxt       = 1'b0;
    w_error_nxt      = 1'b0;
    w_busy_fall      = r_busy_prev & ~tmr.timer_busy;

    unique case (r_state)
      ST_IDLE: begin
        if (w_is_clear) begin
          w_buf_nxt = '0;
        end else if (w_is_start) begin
          w_error_nxt = 1'b1;
        end else if (w_is_digit) begin
          w_buf_nxt   = {12'h000, key_code};
          w_cnt_nxt   = '0;
          w_state_nxt = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (w_is_clear) begin
          w_buf_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_is_digit) begin
          w_buf_nxt = {r_buf[11:0], key_code};
          w_cnt_nxt = '0;
        end else if (w_is_start) begin
          w_cnt_nxt = '0;
          if ((r_buf == '0) || !door_closed) begin
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt      = ST_LOAD;
            w_load_valid_nxt = 1'b1;
`ifdef KEYPAD_SEC_CLAMP_EN
            w_buf_nxt        = clamp_seconds(r_buf);
`endif
          end
        end else if (c_timeout_en) begin
          if (r_cnt == c_cnt_last) begin
            w_buf_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      ST_LOAD: begin
        w_load_valid_nxt = 1'b1;
        if (w_is_clear) begin
          w_load_valid_nxt = 1'b0;
          w_buf_nxt        = '0;
          w_state_nxt      = ST_IDLE;
        end else if (!door_closed) begin
          w_load_valid_nxt = 1'b0;
          w_error_nxt      = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = ST_ENTRY;
        end else if (r_load_valid && tmr.load_ready) begin
          w_load_valid_nxt = 1'b0;
          w_start_nxt      = 1'b1;
          w_state_nxt      = ST_RUN;
        end
      end

      ST_RUN: begin
        if (w_is_clear || !door_closed) begin
          w_stop_nxt  = 1'b1;
          w_buf_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_busy_fall) begin
          w_buf_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign tmr.load_valid = r_load_valid;
  assign tmr.load_time  = r_buf;
  assign tmr.start      = r_start;
  assign tmr.stop       = r_stop;
  assign disp_bcd       = r_buf;
  assign error          = r_error;

  logic w_unused;
  assign w_unused = w_key_ev;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_keypad_entry_ctrl: directed and random checks against a model      |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
module tb_keypad_entry_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_level;
  logic [3:0]  key_code;
  logic        door_closed;
  logic [15:0] disp_bcd;
  logic        error;

  keypad_entry_ctrl_if tif();

  keypad_entry_ctrl #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_level   (key_level),
    .key_code    (key_code),
    .door_closed (door_closed),
    .tmr         (tif),
    .disp_bcd    (disp_bcd),
    .error       (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: user-visible mode, buffer value and idle-cycle count.
  typedef enum int {M_IDLE, M_ENTRY, M_LOAD, M_RUN} mode_e;
  mode_e       m_mode;
  logic [15:0] m_buf;
  int          m_idle;
  bit          m_kprev, m_bprev, m_start, m_stop, m_err;

  function automatic logic [15:0] sec_limit(input logic [15:0] b);
`ifdef KEYPAD_SEC_CLAMP_EN
    if ((b % 256) > 16'h59) return b - (b % 256) + 16'h59;
`endif
    return b;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_buf = 0; m_idle = 0;
    m_kprev = 0; m_bprev = 0; m_start = 0; m_stop = 0; m_err = 0;
  endtask

  task automatic model_edge();
    bit ev, d, s, c, fall;
    ev   = key_level && !m_kprev;
    d    = ev && (key_code <= 4'd9);
    s    = ev && (key_code == 4'hA);
    c    = ev && (key_code == 4'hB);
    fall = m_bprev && !tif.timer_busy;
    m_start = 0; m_stop = 0; m_err = 0;
    case (m_mode)
      M_IDLE: begin
        if (c) m_buf = 0;
        else if (s) m_err = 1;
        else if (d) begin m_buf = 16'(key_code); m_mode = M_ENTRY; m_idle = 0; end
      end
      M_ENTRY: begin
        if (c) begin m_buf = 0; m_mode = M_IDLE; end
        else if (d) begin m_buf = 16'(m_buf * 16 + key_code); m_idle = 0; end
        else if (s) begin
          m_idle = 0;
          if (m_buf == 0 || !door_closed) m_err = 1;
          else begin m_mode = M_LOAD; m_buf = sec_limit(m_buf); end
        end else begin
          m_idle++;
          if (TO != 0 && m_idle == TO) begin m_buf = 0; m_mode = M_IDLE; end
        end
      end
      M_LOAD: begin
        if (c) begin m_buf = 0; m_mode = M_IDLE; end
        else if (!door_closed) begin m_err = 1; m_mode = M_ENTRY; m_idle = 0; end
        else if (tif.load_ready) begin m_start = 1; m_mode = M_RUN; end
      end
      M_RUN: begin
        if (c || !door_closed) begin m_stop = 1; m_buf = 0; m_mode = M_IDLE; end
        else if (fall) begin m_buf = 0; m_mode = M_IDLE; end
      end
      default: m_mode = M_IDLE;
    endcase
    m_kprev = key_level;
    m_bprev = tif.timer_busy;
  endtask

  task automatic check_outputs();
    check_val("disp", disp_bcd, m_buf);
    check_val("load_valid", 16'(tif.load_valid), 16'(m_mode == M_LOAD));
    if (m_mode == M_LOAD) check_val("load_time", tif.load_time, m_buf);
    check_val("start", 16'(tif.start), 16'(m_start));
    check_val("stop", 16'(tif.stop), 16'(m_stop));
    check_val("error", 16'(error), 16'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    #1;
    check_outputs();
  endtask

  task automatic key_down(input logic [3:0] code);
    key_level = 1'b1;
    key_code  = code;
    step();
    key_level = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    key_down(code);
    step();
  endtask

  initial begin
    int hold, gap, r;
    rst = 1'b1; key_level = 1'b0; key_code = 4'h0; door_closed = 1'b1;
    tif.load_ready = 1'b0; tif.timer_busy = 1'b0;
    model_reset();
    step(); step();
    rst = 1'b0;
    check_val("reset_disp", disp_bcd, 16'h0000);

    // Digit entry and shifting
    press(4'd1); press(4'd3); press(4'd0);
    check_val("entry_0130", disp_bcd, 16'h0130);
    press(4'd5);
    check_val("entry_1305", disp_bcd, 16'h1305);
    press(4'd7); press(4'd2);
    check_val("entry_0572", disp_bcd, 16'h0572);
    press(4'hB);
    check_val("clear_disp", disp_bcd, 16'h0000);

    // Start and load with ready held off three cycles
    press(4'd1); press(4'd3); press(4'd0);
    key_down(4'hA);
    check_val("lv_rise", 16'(tif.load_valid), 16'h1);
    step(); step(); step();
    check_val("lv_hold", 16'(tif.load_valid), 16'h1);
    check_val("lt_hold", tif.load_time, 16'h0130);
    tif.load_ready = 1'b1;
    step();
    check_val("start_pulse", 16'(tif.start), 16'h1);
    check_val("lv_drop", 16'(tif.load_valid), 16'h0);
    tif.load_ready = 1'b0;
    step();
    check_val("start_len", 16'(tif.start), 16'h0);

    // Run: digit ignored, then natural finish
    press(4'd9);
    check_val("run_ignore", disp_bcd, 16'h0130);
    tif.timer_busy = 1'b1; step(); step();
    tif.timer_busy = 1'b0; step();
    check_val("finish_disp", disp_bcd, 16'h0000);
    check_val("finish_nostop", 16'(tif.stop), 16'h0);

    // Run aborted by CLEAR, ready raised before valid
    press(4'd4);
    tif.load_ready = 1'b1;
    key_down(4'hA);
    step(); step();
    tif.load_ready = 1'b0;
    key_down(4'hB);
    check_val("run_clear_stop", 16'(tif.stop), 16'h1);
    check_val("run_clear_disp", disp_bcd, 16'h0000);
    step();

    // Rejected starts
    key_down(4'hA);
    check_val("err_idle_start", 16'(error), 16'h1);
    step();
    check_val("err_len", 16'(error), 16'h0);
    press(4'd6);
    door_closed = 1'b0;
    key_down(4'hA);
    check_val("err_door_start", 16'(error), 16'h1);
    check_val("err_door_buf", disp_bcd, 16'h0006);
    step();
    door_closed = 1'b1;
    press(4'hB);

    // Door opens during LOAD
    press(4'd2);
    key_down(4'hA);
    door_closed = 1'b0;
    step();
    check_val("load_door_err", 16'(error), 16'h1);
    check_val("load_door_buf", disp_bcd, 16'h0002);
    door_closed = 1'b1;
    press(4'hB);

    // Entry timeout
    press(4'd5);
    repeat (6) step();
    check_val("pre_timeout", disp_bcd, 16'h0005);
    step();
    check_val("timeout", disp_bcd, 16'h0000);

    // Held key gives one digit
    press(4'd2);
    key_level = 1'b1; key_code = 4'd3;
    repeat (6) step();
    key_level = 1'b0;
    step();
    check_val("held_key", disp_bcd, 16'h0023);
    press(4'hB);

    // Seconds clamp (or raw pass-through)
    press(4'd0); press(4'd1); press(4'd7); press(4'd5);
    key_down(4'hA);
`ifdef KEYPAD_SEC_CLAMP_EN
    check_val("clamp", tif.load_time, 16'h0159);
`else
    check_val("raw_time", tif.load_time, 16'h0175);
`endif
    step();
    press(4'hB);

    // Asynchronous reset during LOAD
    press(4'd1);
    key_down(4'hA);
    #3 rst = 1'b1;
    #1 check_val("async_rst_lv", 16'(tif.load_valid), 16'h0);
    step();
    rst = 1'b0;

    // Randomized traffic
    hold = 0; gap = 0;
    for (int i = 0; i < 3000; i++) begin
      if (key_level) begin
        if (hold > 0) hold--;
        else begin key_level = 1'b0; gap = $urandom_range(0, 5); end
      end else if (gap > 0) begin
        gap--;
      end else begin
        key_level = 1'b1;
        hold = $urandom_range(0, 3);
        r = $urandom_range(0, 99);
        if (r < 55)      key_code = 4'($urandom_range(0, 9));
        else if (r < 72) key_code = 4'hA;
        else if (r < 82) key_code = 4'hB;
        else             key_code = 4'($urandom_range(12, 15));
      end
      door_closed    = ($urandom_range(0, 19) != 0);
      tif.load_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) tif.timer_busy = ~tif.timer_busy;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
